ascon_block_loader: RTL and testbench

Upstream input stage of the ASCON-128 core. It takes a byte stream from the host, packs it big-endian into 64-bit rate blocks, and applies ASCON padding to the final block of each segment. It then presents each block to the control FSM through a valid/ack handshake. The FSM consumes `data_o` while it waits for data before each associated-data and cipher permutation.

---
 rtl/ascon_pack.sv | 23 ++
 rtl/ascon_block_loader.sv | 168 ++++++++++++++++
 tb/tb_ascon_block_loader.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ascon_pack.sv
// ============================================================================
// Package     : ascon_pack
// Description : Shared constants and types for the ASCON-128 input datapath.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ascon_pack;

  localparam int          ASCON_RATE      = 64;
  localparam logic [7:0]  ASCON_PAD_BYTE  = 8'h80;
  localparam logic [63:0] ASCON_PAD_BLOCK = 64'h8000_0000_0000_0000;

  // Loader phases: collecting bytes, holding a block, holding an extra pad block
  typedef enum logic [1:0] {
    FILL    = 2'd0,
    PRESENT = 2'd1,
    PAD     = 2'd2
  } loader_state_t;

endpackage

`default_nettype wire

// File: rtl/ascon_block_loader.sv
// ============================================================================
// Module      : ascon_block_loader
// Description : Packs a host byte stream big-endian into 64-bit rate blocks,
//               applies ASCON 10* padding to the final block of a segment and
//               hands blocks to the control FSM over a valid/ack handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ascon_block_loader
  import ascon_pack::*;
(
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic [7:0]            byte_i,
  input  logic                  byte_valid_i,
  input  logic                  byte_last_i,
  input  logic                  seg_i,
  output logic                  byte_ready_o,
  output logic [ASCON_RATE-1:0] data_o,
  output logic                  data_valid_o,
  output logic                  last_o,
  output logic                  seg_o,
  output logic [1:0]            block_o,
  input  logic                  data_ack_i
);

  // Bytes strictly after position k (the region that padding overwrites)
  function automatic logic [63:0] pad_mask(input logic [2:0] k);
    return 64'h00FF_FFFF_FFFF_FFFF >> {k, 3'b000};
  endfunction

  // Pad byte placed directly after position k; vanishes when k is the last slot
  function automatic logic [63:0] pad_value(input logic [2:0] k);
    return {8'h00, ASCON_PAD_BYTE, 48'h0} >> {k, 3'b000};
  endfunction

  loader_state_t r_state;
  loader_state_t w_state_nxt;

  logic [63:0] r_data;
  logic [2:0]  r_cnt;
  logic [1:0]  r_block;
  logic        r_ready;
  logic        r_valid;
  logic        r_last;
  logic        r_seg;
  logic        r_pad_pend;
  logic        r_seg_first;

  logic        w_accept;
  logic        w_ack;
  logic        w_cnt_is7;
  logic        w_complete;
  logic        w_ready_nxt;
  logic        w_valid_nxt;
  logic [5:0]  w_byte_sh;
  logic [63:0] w_fill_data;

  assign w_accept   = byte_valid_i & r_ready;
  assign w_ack      = data_ack_i & r_valid;
  assign w_cnt_is7  = (r_cnt == 3'd7);
  assign w_complete = w_accept & (byte_last_i | w_cnt_is7);

  // Insert the incoming byte at its slot and, on a last byte, pad the tail
  always_comb begin
    w_byte_sh   = {r_cnt, 3'b000};
    w_fill_data = (r_data & ~(64'hFF00_0000_0000_0000 >> w_byte_sh))
                | ({byte_i, 56'h0} >> w_byte_sh);
    if (byte_last_i) begin
      w_fill_data = (w_fill_data & ~pad_mask(r_cnt)) | pad_value(r_cnt);
    end
  end

  // FSM state register, with the handshake flags registered alongside it
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      r_state <= FILL;
      r_ready <= 1'b1;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ready <= w_ready_nxt;
      r_valid <= w_valid_nxt;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      FILL:    if (w_complete) w_state_nxt = PRESENT;
      PRESENT: if (w_ack)      w_state_nxt = r_pad_pend ? PAD : FILL;
      PAD:     if (w_ack)      w_state_nxt = FILL;
      default:                 w_state_nxt = FILL;
    endcase
  end

  // FSM outputs: bytes are taken only while filling, a block is held otherwise
  always_comb begin
    w_ready_nxt = (w_state_nxt == FILL);
    w_valid_nxt = (w_state_nxt != FILL);
  end

  // Block datapath: packing, padding, segment tag and block index bookkeeping
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      r_data      <= '0;
      r_cnt       <= 3'd0;
      r_block     <= 2'd0;
      r_last      <= 1'b0;
      r_seg       <= 1'b0;
      r_pad_pend  <= 1'b0;
      r_seg_first <= 1'b1;
    end else begin
      if (w_accept) begin
        r_data <= w_fill_data;
        r_cnt  <= w_complete ? 3'd0 : r_cnt + 3'd1;
        if (r_seg_first) begin
          r_seg       <= seg_i;
          r_seg_first <= 1'b0;
        end
        if (w_complete) begin
          // A last byte in the final slot leaves no room: pad goes in its own block
          r_last     <= byte_last_i & ~w_cnt_is7;
          r_pad_pend <= byte_last_i & w_cnt_is7;
        end
      end
      if (w_ack) begin
        unique case (r_state)
          PRESENT: begin
            if (r_pad_pend) begin
              r_data     <= ASCON_PAD_BLOCK;
              r_last     <= 1'b1;
              r_pad_pend <= 1'b0;
              r_block    <= r_block + 2'd1;
            end else begin
              r_last <= 1'b0;
              if (r_last) begin
                r_block     <= 2'd0;
                r_seg_first <= 1'b1;
              end else begin
                r_block <= r_block + 2'd1;
              end
            end
          end
          PAD: begin
            r_last      <= 1'b0;
            r_block     <= 2'd0;
            r_seg_first <= 1'b1;
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign byte_ready_o = r_ready;
  assign data_valid_o = r_valid;
  assign data_o       = r_data;
  assign last_o       = r_last;
  assign seg_o        = r_seg;
  assign block_o      = r_block;

endmodule

`default_nettype wire

// File: tb/tb_ascon_block_loader.sv
// ============================================================================
// Module      : tb_ascon_block_loader
// Description : Scoreboard bench for ascon_block_loader. Segments are turned
//               into expected blocks by padding the byte list and slicing it.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ascon_block_loader;

  typedef struct packed {
    logic [63:0] d;
    logic        l;
    logic        s;
    logic [1:0]  b;
  } exp_t;

  logic        clk;
  logic        reset_i;
  logic [7:0]  byte_i;
  logic        byte_valid_i;
  logic        byte_last_i;
  logic        seg_i;
  logic        byte_ready_o;
  logic [63:0] data_o;
  logic        data_valid_o;
  logic        last_o;
  logic        seg_o;
  logic [1:0]  block_o;
  logic        data_ack_i;
  logic        ack_a;
  logic        ack_s;
  logic        ack_en;

  int   checks;
  int   failures;
  exp_t exp_q[$];
  logic [7:0] seg_bytes[$];

  assign data_ack_i = ack_a | ack_s;

  ascon_block_loader dut (
    .clock_i      (clk),
    .reset_i      (reset_i),
    .byte_i       (byte_i),
    .byte_valid_i (byte_valid_i),
    .byte_last_i  (byte_last_i),
    .seg_i        (seg_i),
    .byte_ready_o (byte_ready_o),
    .data_o       (data_o),
    .data_valid_o (data_valid_o),
    .last_o       (last_o),
    .seg_o        (seg_o),
    .block_o      (block_o),
    .data_ack_i   (data_ack_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference: append 0x80, zero-fill to a multiple of 8, slice big-endian
  task automatic push_expected(input logic s);
    logic [7:0]  p[$];
    logic [63:0] d;
    exp_t        e;
    int          nblk;
    p = seg_bytes;
    p.push_back(8'h80);
    while ((p.size() % 8) != 0) p.push_back(8'h00);
    nblk = p.size() / 8;
    for (int i = 0; i < nblk; i++) begin
      d = '0;
      for (int j = 0; j < 8; j++) d = {d[55:0], p[8*i+j]};
      e.d = d;
      e.l = (i == nblk - 1);
      e.s = s;
      e.b = 2'(i % 4);
      exp_q.push_back(e);
    end
  endtask

  // Offer one byte and hold it until taken; called and returns at posedge+1
  task automatic send_byte(input logic [7:0] b, input logic l, input logic s);
    logic ok;
    int   n;
    byte_i       = b;
    byte_last_i  = l;
    seg_i        = s;
    byte_valid_i = 1'b1;
    ok = 1'b0;
    n  = 0;
    while (n < 300) begin
      @(negedge clk);
      if (byte_ready_o) begin
        @(posedge clk); #1;
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
      n++;
    end
    byte_valid_i = 1'b0;
    byte_last_i  = 1'b0;
    chk("byte_accept_timeout", {63'd0, ok}, 64'd1);
  endtask

  // seg_i is only meaningful on the first byte, so it is scrambled afterwards
  task automatic send_seg(input logic s, input logic gaps);
    push_expected(s);
    for (int i = 0; i < seg_bytes.size(); i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      send_byte(seg_bytes[i], (i == seg_bytes.size() - 1),
                (i == 0) ? s : 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 600; i++) begin
      if (exp_q.size() == 0 && !data_valid_o) break;
      @(posedge clk); #1;
    end
    chk("drain_pending_blocks", 64'(exp_q.size()), 64'd0);
    chk("drain_valid", {63'd0, data_valid_o}, 64'd0);
  endtask

  // Acknowledger: pulses ack after a random number of valid cycles
  initial begin
    int wcnt;
    int dly;
    ack_a = 1'b0;
    wcnt  = 0;
    dly   = 0;
    forever begin
      @(posedge clk); #1;
      ack_a = 1'b0;
      if (ack_en && data_valid_o && !reset_i) begin
        if (wcnt >= dly) begin
          ack_a = 1'b1;
          wcnt  = 0;
          dly   = $urandom_range(0, 3);
        end else begin
          wcnt++;
        end
      end
    end
  end

  // Monitor: a block is consumed when valid and ack meet; held blocks must not move
  initial begin
    exp_t        e;
    logic        have_prev;
    logic [67:0] prev;
    have_prev = 1'b0;
    prev      = '0;
    forever begin
      @(negedge clk);
      if (reset_i) begin
        have_prev = 1'b0;
      end else if (data_valid_o) begin
        if (have_prev) chk("held_block_stable", {60'd0, prev[3:0]} ^ 64'(prev[67:4] ^ data_o),
                           {60'd0, last_o, seg_o, block_o});
        if (data_ack_i) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_unexpected_block actual=%h required=none", data_o);
          end else begin
            e = exp_q.pop_front();
            chk("sb_data",  data_o, e.d);
            chk("sb_last",  {63'd0, last_o}, {63'd0, e.l});
            chk("sb_seg",   {63'd0, seg_o}, {63'd0, e.s});
            chk("sb_block", {62'd0, block_o}, {62'd0, e.b});
          end
          have_prev = 1'b0;
        end else begin
          have_prev = 1'b1;
          prev      = {data_o, last_o, seg_o, block_o};
        end
      end else begin
        have_prev = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, {63'd0, byte_ready_o}, 64'd1);
    chk({tag, "_valid"}, {63'd0, data_valid_o}, 64'd0);
    chk({tag, "_data"},  data_o, 64'd0);
    chk({tag, "_last"},  {63'd0, last_o}, 64'd0);
    chk({tag, "_seg"},   {63'd0, seg_o}, 64'd0);
    chk({tag, "_block"}, {62'd0, block_o}, 64'd0);
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    reset_i      = 1'b1;
    byte_i       = 8'h00;
    byte_valid_i = 1'b0;
    byte_last_i  = 1'b0;
    seg_i        = 1'b0;
    ack_s        = 1'b0;
    ack_en       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    reset_i = 1'b0;
    @(posedge clk); #1;
    ack_en = 1'b1;

    // Full final block followed by a separate pad block
    seg_bytes = {};
    for (int i = 0; i < 8; i++) seg_bytes.push_back(8'(i));
    send_seg(1'b1, 1'b0);

    // Short associated-data segment padded in place
    seg_bytes = {8'hAA, 8'hBB, 8'hCC};
    send_seg(1'b0, 1'b0);

    // Four full blocks, index wraps on the pad block
    seg_bytes = {};
    for (int i = 0; i < 32; i++) seg_bytes.push_back(8'(i));
    send_seg(1'b1, 1'b0);
    wait_drain();

    // Single byte segment, ack withheld while another byte is offered
    ack_en    = 1'b0;
    seg_bytes = {8'h5A};
    send_seg(1'b0, 1'b0);
    byte_valid_i = 1'b1;
    byte_i       = 8'h11;
    byte_last_i  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_valid", {63'd0, data_valid_o}, 64'd1);
      chk("hold_data",  data_o, 64'h5A80_0000_0000_0000);
      chk("hold_ready", {63'd0, byte_ready_o}, 64'd0);
    end
    @(posedge clk); #1;
    byte_valid_i = 1'b0;
    ack_s = 1'b1;
    @(posedge clk); #1;
    ack_s = 1'b0;
    chk("post_ack_ready", {63'd0, byte_ready_o}, 64'd1);
    chk("post_ack_valid", {63'd0, data_valid_o}, 64'd0);

    // Ack with nothing presented must not create a block
    ack_s = 1'b1;
    @(posedge clk); #1;
    ack_s = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("stray_ack_valid", {63'd0, data_valid_o}, 64'd0);
      chk("stray_ack_ready", {63'd0, byte_ready_o}, 64'd1);
      chk("stray_ack_block", {62'd0, block_o}, 64'd0);
    end
    @(posedge clk); #1;

    // Randomized segments with idle gaps and random ack latency
    ack_en = 1'b1;
    for (int s = 0; s < 40; s++) begin
      seg_bytes = {};
      for (int i = 0; i < int'($urandom_range(1, 20)); i++) seg_bytes.push_back(8'($urandom));
      send_seg(1'($urandom_range(0, 1)), 1'b1);
    end
    wait_drain();

    // Reset in the middle of a block discards the partial bytes
    for (int i = 1; i <= 4; i++) send_byte(8'(i), 1'b0, 1'b1);
    #2;
    reset_i = 1'b1;
    #1;
    chk_reset_outputs("async_reset");
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_i = 1'b0;
    @(posedge clk); #1;
    seg_bytes = {8'h10, 8'h21, 8'h32, 8'h43, 8'h54, 8'h65, 8'h76, 8'h87};
    send_seg(1'b1, 1'b0);
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
